affine2_op2_loader: RTL and testbench
=====================================

Name: affine2_op2_loader

Overview:
- Serial-to-parallel loader that sits directly in front of the affine2 stage-2 adder.
- Accepts stage-1 results one 9-bit word per cycle over a valid/ready handshake and collects 32 of them into a register bank.
- Presents the bank as the adder's 32 parallel 9-bit operands, with a valid/ready handshake on the output side.
- Holds the operands stable until the downstream side accepts them.

Parameters:
- DATA_WIDTH, 9, width of one operand word (matches adder input width).
- NUM, 32, number of words per frame (matches adder input count).
- CNT_WIDTH, 5, width of the fill counter; must satisfy 2**CNT_WIDTH >= NUM.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  serial operand word.
- in_valid  input  1  in_data is valid this cycle.
- in_last  input  1  marks the final word of a frame; qualified by in_valid.
- in_ready  output  1  loader can accept a word this cycle.
- data_out  output  NUM*DATA_WIDTH  parallel operands; word k is data_out[k*DATA_WIDTH+DATA_WIDTH-1 : k*DATA_WIDTH], wired to the adder's data<k> input.
- out_valid  output  1  data_out holds a complete frame.
- out_ready  input  1  downstream accepts the frame this cycle.
- frame_err  output  1  sticky framing-error flag.
- count  output  CNT_WIDTH  number of words already stored in the current frame.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=FILL, count=0, data_out=0, out_valid=0, frame_err=0; in_ready is 1 from the first cycle after reset.
  - Reset asserted mid-frame or in HOLD discards all stored words. No partial frame survives.
- States: FILL, HOLD.
  - in_ready = (state==FILL). out_valid = (state==HOLD). Both outputs are decoded from registered state only; no combinational path from inputs.
- Input accept: happens when in_valid && in_ready.
  - Word k=count is written into slot k. Other slots are unchanged.
  - If count==NUM-1: write slot NUM-1, set count=0, go to HOLD. out_valid rises the next cycle.
  - Otherwise count increments by 1.
- in_last rules, evaluated only on an accepted word:
  - in_last=1 with count==NUM-1: normal frame end.
  - in_last=1 with count<NUM-1 (short frame): the word is written, frame_err is set, count returns to 0, state stays FILL, and no frame is presented. Stale slot contents remain on data_out but are never flagged valid.
  - in_last=0 with count==NUM-1 (long frame): frame_err is set, but the frame still completes and goes to HOLD.
- HOLD:
  - data_out is frozen and in_data is ignored.
  - out_ready=1 returns the state to FILL on the next edge. count is already 0, so a new word can be accepted in the cycle after the handshake.
  - Output handshake latency is 1 cycle. There is no same-cycle pass-through from accept to refill.
- Throughput: one frame per NUM+1 cycles maximum (NUM accept cycles plus 1 HOLD cycle when out_ready is held high).
- frame_err is cleared only by reset.
- in_valid without in_ready has no effect; the upstream holds its word.
- data_out word k changes only on an accepted write to slot k or on reset.

Test Plan:
- Reset, then stream words 1..32 with in_valid=1 continuously, in_last only on word 32, out_ready=1:
  - in_ready drops the cycle after word 32; out_valid=1 for exactly 1 cycle.
  - data_out word k = k+1; frame_err=0; the next frame is accepted on the following cycle.
- Full frame with out_ready=0 for 10 cycles:
  - out_valid stays 1 and data_out stays stable; in_valid=1 with in_data=9'h1FF is ignored.
  - After out_ready=1, in_ready returns 1 cycle later.
- Short frame: 5 words (values 7) with in_last on word 5:
  - frame_err=1 and out_valid never asserts; count returns to 0.
  - A following correct 32-word frame presents normally, and frame_err stays 1.
- Long frame: 32 words of 9'h100 with in_last=0 throughout:
  - frame_err=1; out_valid asserts; every word = 9'h100.
- Reset mid-frame after 17 words:
  - count=0 and data_out=0 the next cycle.
  - A fresh 32-word frame of 3s completes with all words = 3.
- Gapped input: in_valid toggles 1,0,1,0 across 64 cycles:
  - exactly 32 accepts; count advances only on accepted words; out_valid after the 32nd accept.

Source files
------------

// File: rtl/affine2_op2_loader_if.sv
// affine2_op2_loader_if: serial-in / parallel-out handshake bundle for the stage-2 operand loader
interface affine2_op2_loader_if #(
  parameter int DATA_WIDTH = 9,
  parameter int NUM = 32,
  parameter int CNT_WIDTH = 5
);
  logic [DATA_WIDTH-1:0] in_data;
  logic in_valid;
  logic in_last;
  logic in_ready;
  logic [NUM*DATA_WIDTH-1:0] data_out;
  logic out_valid;
  logic out_ready;
  logic frame_err;
  logic [CNT_WIDTH-1:0] count;
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input in_ready, data_out, out_valid, frame_err, count
  );
  modport slave (
    input in_data, in_valid, in_last, out_ready,
    output in_ready, data_out, out_valid, frame_err, count
  );
endinterface

// File: rtl/affine2_op2_loader.sv
// affine2_op2_loader: collects NUM serial words into a bank presented as the stage-2 adder operands
module affine2_op2_loader #(
  parameter int DATA_WIDTH = 9,
  parameter int NUM = 32,
  parameter int CNT_WIDTH = 5
) (
  input logic clock,
  input logic reset,
  affine2_op2_loader_if.slave bus
);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] words [NUM];
  logic err;
  logic at_end;
  assign at_end = cnt == CNT_WIDTH'(NUM - 1);
  assign bus.in_ready = state == FILL;
  assign bus.out_valid = state == HOLD;
  assign bus.frame_err = err;
  assign bus.count = cnt;
  for (genvar k = 0; k < NUM; k++) begin : g_out
    assign bus.data_out[k*DATA_WIDTH +: DATA_WIDTH] = words[k];
  end
  // Framing error whenever in_last disagrees with the slot position: short or long frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FILL;
      cnt <= '0;
      err <= 1'b0;
      for (int i = 0; i < NUM; i++) words[i] <= '0;
    end else if (state == HOLD) begin
      if (bus.out_ready) state <= FILL;
    end else if (bus.in_valid) begin
      words[cnt] <= bus.in_data;
      cnt <= (at_end || bus.in_last) ? '0 : cnt + CNT_WIDTH'(1);
      if (at_end) state <= HOLD;
      if (at_end != bus.in_last) err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_affine2_op2_loader.sv
// tb_affine2_op2_loader: directed scoreboard bench for the stage-2 operand loader
module tb_affine2_op2_loader;
  localparam int DW = 9;
  localparam int N = 32;
  localparam int CW = 5;
  localparam int BW = N * DW;
  logic clock = 0;
  logic reset = 0;
  int checks = 0;
  int fails = 0;
  int vc = 0;
  int v0;
  logic [DW-1:0] fv [N];
  logic [BW-1:0] sb [$];
  logic [BW-1:0] last_frame;
  affine2_op2_loader_if #(.DATA_WIDTH(DW), .NUM(N), .CNT_WIDTH(CW)) bus ();
  affine2_op2_loader #(.DATA_WIDTH(DW), .NUM(N), .CNT_WIDTH(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.out_valid) vc++;
  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  // Drives n words from fv; last_mode 0 marks the final word, 1 never asserts in_last.
  task automatic send(input int n, input int last_mode, input bit gap);
    logic [BW-1:0] ex;
    for (int i = 0; i < n; i++) begin
      int t = 0;
      bus.in_data = fv[i];
      bus.in_valid = 1;
      bus.in_last = (last_mode == 0 && i == n - 1);
      while (!bus.in_ready && t < 50) begin
        tick();
        t++;
      end
      chk("accept_wait", 288'(t < 50), 288'(1));
      tick();
      chk("count", 288'(bus.count), 288'((i == N - 1 || (last_mode == 0 && i == n - 1)) ? 0 : i + 1));
      if (gap && i != n - 1) begin
        bus.in_valid = 0;
        tick();
        chk("count_gap", 288'(bus.count), 288'(i + 1));
      end
    end
    bus.in_valid = 0;
    bus.in_last = 0;
    if (n == N) begin
      for (int k = 0; k < N; k++) ex[k*DW +: DW] = fv[k];
      sb.push_back(ex);
    end
  endtask
  task automatic wait_frame(input string tag);
    int t = 0;
    while (!bus.out_valid && t < 50) begin
      tick();
      t++;
    end
    chk({tag, "_valid"}, 288'(bus.out_valid), 288'(1));
    chk({tag, "_sb_nonempty"}, 288'(sb.size() > 0), 288'(1));
    if (sb.size() > 0) begin
      last_frame = sb.pop_front();
      chk({tag, "_data"}, bus.data_out, last_frame);
    end
  endtask
  initial begin
    bus.in_data = 0;
    bus.in_valid = 0;
    bus.in_last = 0;
    bus.out_ready = 1;
    do_reset();
    chk("rst_in_ready", 288'(bus.in_ready), 288'(1));
    chk("rst_out_valid", 288'(bus.out_valid), 288'(0));
    chk("rst_count", 288'(bus.count), 288'(0));
    chk("rst_data", bus.data_out, 288'(0));
    chk("rst_err", 288'(bus.frame_err), 288'(0));
    // Frame 1: words 1..32, downstream always ready
    for (int k = 0; k < N; k++) fv[k] = DW'(k + 1);
    send(N, 0, 0);
    chk("f1_in_ready_low", 288'(bus.in_ready), 288'(0));
    wait_frame("f1");
    v0 = vc;
    tick();
    chk("f1_valid_one_cycle", 288'(vc - v0), 288'(1));
    chk("f1_out_valid_low", 288'(bus.out_valid), 288'(0));
    chk("f1_in_ready_back", 288'(bus.in_ready), 288'(1));
    chk("f1_err", 288'(bus.frame_err), 288'(0));
    // Frame 2: downstream stalls for 10 cycles while junk is offered
    bus.out_ready = 0;
    for (int k = 0; k < N; k++) fv[k] = DW'(k * 7 + 3);
    send(N, 0, 0);
    wait_frame("f2");
    bus.in_data = 9'h1FF;
    bus.in_valid = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("f2_hold_valid", 288'(bus.out_valid), 288'(1));
      chk("f2_hold_data", bus.data_out, last_frame);
    end
    chk("f2_hold_in_ready", 288'(bus.in_ready), 288'(0));
    bus.in_valid = 0;
    bus.out_ready = 1;
    tick();
    chk("f2_release_in_ready", 288'(bus.in_ready), 288'(1));
    chk("f2_release_valid", 288'(bus.out_valid), 288'(0));
    chk("f2_release_data", bus.data_out, last_frame);
    // Short frame: five 7s with in_last on the fifth word
    for (int k = 0; k < N; k++) fv[k] = 9'd7;
    v0 = vc;
    send(5, 0, 0);
    for (int c = 0; c < 3; c++) tick();
    chk("short_err", 288'(bus.frame_err), 288'(1));
    chk("short_no_valid", 288'(vc - v0), 288'(0));
    chk("short_count", 288'(bus.count), 288'(0));
    chk("short_in_ready", 288'(bus.in_ready), 288'(1));
    for (int k = 0; k < N; k++) fv[k] = DW'(N - k);
    send(N, 0, 0);
    wait_frame("after_short");
    chk("after_short_err", 288'(bus.frame_err), 288'(1));
    // Long frame from a clean error state
    tick();
    do_reset();
    chk("long_pre_err", 288'(bus.frame_err), 288'(0));
    for (int k = 0; k < N; k++) fv[k] = 9'h100;
    send(N, 1, 0);
    wait_frame("long");
    chk("long_err", 288'(bus.frame_err), 288'(1));
    // Reset after 17 words discards the partial frame
    tick();
    for (int k = 0; k < N; k++) fv[k] = DW'(k + 40);
    send(17, 1, 0);
    do_reset();
    chk("midrst_count", 288'(bus.count), 288'(0));
    chk("midrst_data", bus.data_out, 288'(0));
    chk("midrst_err", 288'(bus.frame_err), 288'(0));
    for (int k = 0; k < N; k++) fv[k] = 9'd3;
    send(N, 0, 0);
    wait_frame("threes");
    // Gapped input: every accept followed by an idle cycle
    tick();
    for (int k = 0; k < N; k++) fv[k] = DW'(k) ^ 9'h155;
    v0 = vc;
    send(N, 0, 1);
    chk("gap_no_early_valid", 288'(vc - v0), 288'(0));
    wait_frame("gap");
    chk("gap_err", 288'(bus.frame_err), 288'(0));
    chk("sb_drained", 288'(sb.size()), 288'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
